bus_slave_select: RTL and testbench

Parametrised, registered bus slave-select unit: the next generation of the bus 3-to-8 decoder. It decodes a master's select field into a one-hot chip-select and holds it for the whole transaction until the addressed slave acknowledges. It flags unmapped selects and slave timeouts, and keeps a saturating error count. It sits between the bus master and the slave chip-select lines.

---
 rtl/bus_slave_select_if.sv | 33 +++
 rtl/bus_slave_select.sv | 114 +++++++++++
 tb/tb_bus_slave_select.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/bus_slave_select_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_slave_select_if
// Brief    : Master-to-slave-select bundle: request/select in, chip-selects,
//            status and error count out.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_slave_select_if #(
    parameter int SEL_W  = 3,
    parameter int N_SLV  = 8,
    parameter int ERRC_W = 8
);
    logic              req;
    logic [SEL_W-1:0]  sel;
    logic [N_SLV-1:0]  ack_in;
    logic [N_SLV-1:0]  cs;
    logic              busy;
    logic              done;
    logic              err;
    logic [SEL_W-1:0]  cur_sel;
    logic [ERRC_W-1:0] err_cnt;

    modport master (
        output req, sel, ack_in,
        input  cs, busy, done, err, cur_sel, err_cnt
    );

    modport slave (
        input  req, sel, ack_in,
        output cs, busy, done, err, cur_sel, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/bus_slave_select.sv
`default_nettype none
// ============================================================================
// Module   : bus_slave_select
// Brief    : Registered slave-select decoder holding a one-hot chip-select
//            until ack, with unmapped/timeout error flagging and counting.
// Revision : 1.0 - initial release
// ============================================================================
module bus_slave_select #(
    parameter int SEL_W   = 3,
    parameter int N_SLV   = 8,
    parameter int TIMEOUT = 15,
    parameter int ERRC_W  = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    bus_slave_select_if.slave   bus
);

    localparam int              TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]   TMAX  = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit              TO_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FIN    = 2'd2
    } state_t;

    state_t             state_q;
    logic [N_SLV-1:0]   cs_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [SEL_W-1:0]   cur_sel_q;
    logic [ERRC_W-1:0]  err_cnt_q;
    logic [TW-1:0]      timer_q;

    logic               w_ack_hit;
    logic               w_sel_ok;
    logic [ERRC_W-1:0]  w_cnt_next;

    // cs_q is one-hot on the captured select while ACTIVE, so masking with it
    // honours only the addressed slave's acknowledge.
    assign w_ack_hit  = |(bus.ack_in & cs_q);
    assign w_sel_ok   = (32'(bus.sel) < 32'(N_SLV));
    assign w_cnt_next = (&err_cnt_q) ? err_cnt_q : (err_cnt_q + ERRC_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cs_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cur_sel_q <= '0;
            err_cnt_q <= '0;
            timer_q   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req) begin
                        cur_sel_q <= bus.sel;
                        busy_q    <= 1'b1;
                        if (w_sel_ok) begin
                            state_q <= S_ACTIVE;
                            cs_q    <= N_SLV'(1) << bus.sel;
                            timer_q <= '0;
                        end else begin
                            state_q   <= S_FIN;
                            done_q    <= 1'b1;
                            err_q     <= 1'b1;
                            err_cnt_q <= w_cnt_next;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (w_ack_hit) begin
                        state_q <= S_FIN;
                        cs_q    <= '0;
                        done_q  <= 1'b1;
                    end else if (TO_EN && (timer_q == TMAX)) begin
                        state_q   <= S_FIN;
                        cs_q      <= '0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                        err_cnt_q <= w_cnt_next;
                    end else if (TO_EN) begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    cs_q    <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cs      = cs_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.cur_sel = cur_sel_q;
    assign bus.err_cnt = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_slave_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_slave_select
// Brief    : Directed bench for bus_slave_select, default and reduced configs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_slave_select;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    // Default configuration: 8 slaves, TIMEOUT 15, 8-bit counter.
    bus_slave_select_if #(.SEL_W(3), .N_SLV(8), .ERRC_W(8)) ifa ();
    // Reduced configuration: 6 slaves, TIMEOUT 4, 2-bit counter.
    bus_slave_select_if #(.SEL_W(3), .N_SLV(6), .ERRC_W(2)) ifb ();

    bus_slave_select #(.SEL_W(3), .N_SLV(8), .TIMEOUT(15), .ERRC_W(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    bus_slave_select #(.SEL_W(3), .N_SLV(6), .TIMEOUT(4), .ERRC_W(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifa.req = 1'b0; ifa.sel = '0; ifa.ack_in = '0;
        ifb.req = 1'b0; ifb.sel = '0; ifb.ack_in = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_vec++; if (ifa.cs !== 8'h00) begin n_err++; $display("FAIL reset_cs got %h want 00", ifa.cs); end
        n_vec++; if (ifa.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", ifa.busy); end
        n_vec++; if (ifa.done !== 1'b0 || ifa.err !== 1'b0) begin n_err++; $display("FAIL reset_done_err got %b%b want 00", ifa.done, ifa.err); end
        n_vec++; if (ifa.cur_sel !== 3'd0) begin n_err++; $display("FAIL reset_cur_sel got %0d want 0", ifa.cur_sel); end
        n_vec++; if (ifa.err_cnt !== 8'd0) begin n_err++; $display("FAIL reset_err_cnt got %0d want 0", ifa.err_cnt); end
        n_vec++; if (ifb.err_cnt !== 2'd0) begin n_err++; $display("FAIL reset_err_cnt_b got %0d want 0", ifb.err_cnt); end
    endtask

    task automatic test_mapped_ack();
        ifa.sel = 3'd5; ifa.req = 1'b1;
        tick();
        ifa.req = 1'b0;
        n_vec++; if (ifa.cs !== 8'h20 || ifa.busy !== 1'b1) begin n_err++; $display("FAIL ack_cs1 got cs=%h busy=%b want cs=20 busy=1", ifa.cs, ifa.busy); end
        tick();
        n_vec++; if (ifa.cs !== 8'h20 || ifa.done !== 1'b0) begin n_err++; $display("FAIL ack_cs2 got cs=%h done=%b want cs=20 done=0", ifa.cs, ifa.done); end
        ifa.ack_in = 8'h20;
        tick();
        ifa.ack_in = 8'h00;
        n_vec++; if (ifa.cs !== 8'h00) begin n_err++; $display("FAIL ack_cs_clear got %h want 00", ifa.cs); end
        n_vec++; if (ifa.done !== 1'b1 || ifa.err !== 1'b0) begin n_err++; $display("FAIL ack_done got done=%b err=%b want done=1 err=0", ifa.done, ifa.err); end
        n_vec++; if (ifa.cur_sel !== 3'd5 || ifa.err_cnt !== 8'd0) begin n_err++; $display("FAIL ack_status got cur_sel=%0d cnt=%0d want 5 0", ifa.cur_sel, ifa.err_cnt); end
        tick();
        n_vec++; if (ifa.done !== 1'b0 || ifa.busy !== 1'b0 || ifa.cur_sel !== 3'd5) begin n_err++; $display("FAIL ack_idle got done=%b busy=%b cur_sel=%0d want 0 0 5", ifa.done, ifa.busy, ifa.cur_sel); end
    endtask

    task automatic test_timeout();
        int hi;
        hi = 0;
        ifa.sel = 3'd2; ifa.ack_in = 8'h01; ifa.req = 1'b1;
        tick();
        ifa.req = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (ifa.cs === 8'h04) hi++;
            if (i < 14) tick();
        end
        n_vec++; if (hi != 15) begin n_err++; $display("FAIL timeout_cs_cycles got %0d want 15", hi); end
        tick();
        n_vec++; if (ifa.cs !== 8'h00 || ifa.done !== 1'b1 || ifa.err !== 1'b1) begin n_err++; $display("FAIL timeout_done got cs=%h done=%b err=%b want 00 1 1", ifa.cs, ifa.done, ifa.err); end
        n_vec++; if (ifa.err_cnt !== 8'd1) begin n_err++; $display("FAIL timeout_cnt got %0d want 1", ifa.err_cnt); end
        tick();
        ifa.ack_in = 8'h00;
        n_vec++; if (ifa.err !== 1'b0 || ifa.busy !== 1'b0) begin n_err++; $display("FAIL timeout_idle got err=%b busy=%b want 0 0", ifa.err, ifa.busy); end
    endtask

    task automatic test_unmapped();
        ifb.sel = 3'd7; ifb.req = 1'b1;
        tick();
        ifb.req = 1'b0;
        n_vec++; if (ifb.cs !== 6'h00 || ifb.done !== 1'b1 || ifb.err !== 1'b1) begin n_err++; $display("FAIL unmapped_fin got cs=%h done=%b err=%b want 00 1 1", ifb.cs, ifb.done, ifb.err); end
        n_vec++; if (ifb.err_cnt !== 2'd1 || ifb.cur_sel !== 3'd7) begin n_err++; $display("FAIL unmapped_status got cnt=%0d cur_sel=%0d want 1 7", ifb.err_cnt, ifb.cur_sel); end
        tick();
        n_vec++; if (ifb.cs !== 6'h00 || ifb.done !== 1'b0 || ifb.busy !== 1'b0) begin n_err++; $display("FAIL unmapped_idle got cs=%h done=%b busy=%b want 00 0 0", ifb.cs, ifb.done, ifb.busy); end
    endtask

    task automatic test_ack_on_timeout_edge();
        ifb.sel = 3'd1; ifb.req = 1'b1;
        tick();
        ifb.req = 1'b0;
        tick(); tick(); tick();
        n_vec++; if (ifb.cs !== 6'h02 || ifb.done !== 1'b0) begin n_err++; $display("FAIL tedge_active got cs=%h done=%b want 02 0", ifb.cs, ifb.done); end
        ifb.ack_in = 6'h02;
        tick();
        ifb.ack_in = 6'h00;
        n_vec++; if (ifb.done !== 1'b1 || ifb.err !== 1'b0 || ifb.cs !== 6'h00) begin n_err++; $display("FAIL tedge_done got done=%b err=%b cs=%h want 1 0 00", ifb.done, ifb.err, ifb.cs); end
        n_vec++; if (ifb.err_cnt !== 2'd1) begin n_err++; $display("FAIL tedge_cnt got %0d want 1", ifb.err_cnt); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [8:0] pat;
        pat = '0;
        ifa.sel = 3'd3; ifa.ack_in = 8'h08; ifa.req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            pat[i] = (ifa.cs === 8'h08);
        end
        n_vec++; if (pat !== 9'b001_001_001) begin n_err++; $display("FAIL b2b_pattern got %b want 001001001", pat); end
        ifa.req = 1'b0; ifa.ack_in = 8'h00;
        tick(); tick(); tick();
        ifa.req = 1'b1;
        tick();
        ifa.req = 1'b0;
        n_vec++; if (ifa.cs !== 8'h08 || ifa.err_cnt !== 8'd1) begin n_err++; $display("FAIL b2b_pre_reset got cs=%h cnt=%0d want 08 1", ifa.cs, ifa.err_cnt); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (ifa.cs !== 8'h00 || ifa.busy !== 1'b0) begin n_err++; $display("FAIL async_reset got cs=%h busy=%b want 00 0", ifa.cs, ifa.busy); end
        n_vec++; if (ifa.done !== 1'b0 || ifa.err_cnt !== 8'd0) begin n_err++; $display("FAIL async_reset_cnt got done=%b cnt=%0d want 0 0", ifa.done, ifa.err_cnt); end
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (ifa.done !== 1'b0 || ifa.busy !== 1'b0) begin n_err++; $display("FAIL post_reset_%0d got done=%b busy=%b want 0 0", i, ifa.done, ifa.busy); end
        end
    endtask

    task automatic test_saturation();
        n_vec++; if (ifb.err_cnt !== 2'd0) begin n_err++; $display("FAIL sat_start got %0d want 0", ifb.err_cnt); end
        ifb.sel = 3'd6; ifb.req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (ifb.done !== 1'b1 || ifb.err_cnt !== ((i < 3) ? 2'(i + 1) : 2'd3)) begin n_err++; $display("FAIL sat_%0d got done=%b cnt=%0d want 1 %0d", i, ifb.done, ifb.err_cnt, (i < 3) ? i + 1 : 3); end
            tick();
        end
        ifb.req = 1'b0;
        tick();
        n_vec++; if (ifb.err_cnt !== 2'd3) begin n_err++; $display("FAIL sat_final got %0d want 3", ifb.err_cnt); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_mapped_ack();
        test_timeout();
        test_unmapped();
        test_ack_on_timeout_edge();
        test_back_to_back();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
